iterative_shifter: RTL

- Multi-cycle ARM data-processing shifter. It consumes the 5-bit shift amount produced by the shift-amount selector stage, plus the operand and shift type.
- Produces the shifted operand and the shifter carry-out for the ALU.
- Shifts STEP bits per cycle under a start/busy/done handshake.
- Decodes the ARM immediate-shift special encodings (LSR #32, ASR #32, RRX).

---
 rtl/iterative_shifter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/iterative_shifter.sv
// ARM data-processing shifter: shifts STEP bits per cycle behind a start/busy/done handshake.
// Decodes the immediate-field special encodings (LSR #32, ASR #32, RRX) before shifting.
// Optional macro SHIFTER_FAST_EN replaces the iterative loop with a single-cycle barrel path.
module iterative_shifter #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] operand,
  input  logic [4:0]  amount,
  input  logic [1:0]  shift_type,
  input  logic        imm_mode,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic        carry_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sreg_q, sreg_d;      // working shift register
  logic [5:0]  cnt_q, cnt_d;        // bits still to shift
  logic [1:0]  type_q, type_d;      // captured shift type
  logic        sign_q, sign_d;      // captured operand[31] for ASR fill
  logic        cy_q, cy_d;          // last bit shifted out so far
  logic [31:0] result_q, result_d;
  logic        carry_q, carry_d;

  // One-bit shift step: returns {bit shifted out, new value}.
  function automatic logic [32:0] shift1(input logic [31:0] v, input logic [1:0] t,
                                         input logic sgn);
    case (t)
      2'b00:   shift1 = {v[31], v[30:0], 1'b0};
      2'b01:   shift1 = {v[0], 1'b0, v[31:1]};
      2'b10:   shift1 = {v[0], sgn, v[31:1]};
      default: shift1 = {v[0], v[0], v[31:1]};
    endcase
  endfunction

  logic [5:0] eff_amt;
  logic       is_rrx;

  // Effective amount: an immediate amount of zero means #32 for LSR/ASR and RRX for ROR.
  always_comb begin
    eff_amt = {1'b0, amount};
    is_rrx  = 1'b0;
    if (imm_mode && amount == 5'd0) begin
      case (shift_type)
        2'b01, 2'b10: eff_amt = 6'd32;
        2'b11:        is_rrx  = 1'b1;
        default:      eff_amt = 6'd0;
      endcase
    end
  end

  logic [31:0] step_v;
  logic        step_c;
  logic [32:0] step_tmp;
  logic [5:0]  step_k;

  // One SHIFT cycle: up to STEP single-bit steps, stopping when the count runs out.
  always_comb begin
    step_v   = sreg_q;
    step_c   = cy_q;
    step_tmp = {cy_q, sreg_q};
    step_k   = (cnt_q < 6'(STEP)) ? cnt_q : 6'(STEP);
    for (int i = 0; i < STEP; i++) begin
      if (6'(i) < cnt_q) begin
        step_tmp = shift1(step_v, type_q, sign_q);
        step_c   = step_tmp[32];
        step_v   = step_tmp[31:0];
      end
    end
  end

`ifdef SHIFTER_FAST_EN
  logic [31:0] fast_v;
  logic        fast_c;
  logic [32:0] fast_tmp;

  // Full-width barrel result straight from the inputs, built from the same bit step.
  always_comb begin
    fast_v   = operand;
    fast_c   = carry_in;
    fast_tmp = {carry_in, operand};
    for (int i = 0; i < 32; i++) begin
      if (6'(i) < eff_amt) begin
        fast_tmp = shift1(fast_v, shift_type, operand[31]);
        fast_c   = fast_tmp[32];
        fast_v   = fast_tmp[31:0];
      end
    end
  end
`endif

  // Next-state and datapath: finish or continue a shift, then accept a new request when not busy.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    sign_d   = sign_q;
    cy_d     = cy_q;
    result_d = result_q;
    carry_d  = carry_q;

    case (state_q)
      SHIFT: begin
        sreg_d = step_v;
        cy_d   = step_c;
        cnt_d  = cnt_q - step_k;
        if (cnt_q == step_k) begin
          result_d = step_v;
          carry_d  = step_c;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != SHIFT && start) begin
      if (is_rrx) begin
        result_d = {carry_in, operand[31:1]};
        carry_d  = operand[0];
        state_d  = DONE;
      end else if (eff_amt == 6'd0) begin
        result_d = operand;
        carry_d  = carry_in;
        state_d  = DONE;
      end else begin
`ifdef SHIFTER_FAST_EN
        result_d = fast_v;
        carry_d  = fast_c;
        state_d  = DONE;
`else
        sreg_d  = operand;
        cnt_d   = eff_amt;
        type_d  = shift_type;
        sign_d  = operand[31];
        cy_d    = carry_in;
        state_d = SHIFT;
`endif
      end
    end
  end

  // State registers; reset abandons any shift in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sreg_q   <= 32'd0;
      cnt_q    <= 6'd0;
      type_q   <= 2'd0;
      sign_q   <= 1'b0;
      cy_q     <= 1'b0;
      result_q <= 32'd0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      sign_q   <= sign_d;
      cy_q     <= cy_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);

endmodule
